multicycle_control_fsm: RTL and testbench

//  Parametrised multicycle control unit for the RV32I-subset core: latches fetched instr, decodes rs1/rs2/rd/imm/ALUOp,

---
 rtl/multicycle_control_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RV32I-subset control unit
//
// Purpose: latches the fetched instruction, decodes register fields, immediate
// and ALU operation, and sequences IFETCH -> DECODE -> EXEC -> [MEM] -> WB with
// imem/dmem hit handshakes, a sticky halt and an optional memory-wait timeout.
//
// Ports:
//   CLK, nRST           clock (rising edge), asynchronous active-low reset
//   ins, ihit           imem read data and access-complete
//   dhit                dmem access-complete
//   br_taken            ALU branch compare result, sampled in EXEC
//   imemREN             instruction read request (IFETCH)
//   dmemREN, dmemWEN    data read (LW) / write (SW) request (MEM)
//   irEN                instruction-register / PC+4 capture strobe
//   pcEN, PCSrc         PC update strobe and target select (WB)
//   RegWr, MemtoReg     regfile write enable and dmem writeback select (WB)
//   ALUSrc              ALU B operand from immediate
//   rs1, rs2, rd, imm   fields of the latched instruction
//   ALUOp               0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU
//   halt, err           sticky stop and sticky error (illegal opcode / timeout)

module multicycle_control_fsm #(
   parameter int WORD_W      = 32,
   parameter int REG_W       = 5,
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic [WORD_W-1:0]  ins,
   input  logic               ihit,
   input  logic               dhit,
   input  logic               br_taken,
   output logic               imemREN,
   output logic               dmemREN,
   output logic               dmemWEN,
   output logic               irEN,
   output logic               pcEN,
   output logic               PCSrc,
   output logic               RegWr,
   output logic               ALUSrc,
   output logic               MemtoReg,
   output logic [REG_W-1:0]   rs1,
   output logic [REG_W-1:0]   rs2,
   output logic [REG_W-1:0]   rd,
   output logic [WORD_W-1:0]  imm,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               halt,
   output logic               err
);

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MEM_TIMEOUT);

   typedef enum logic [2:0] {
      S_IFETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  ir_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               err_q, err_set, pcsrc_q;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        f7b5;
   logic        is_r, is_i, is_lw, is_sw, is_br, is_jal, is_lui, legal, all_ones;
   logic        timeout;
   logic [31:0] imm32;
   logic [3:0]  aluop4;

   assign opcode   = ir_q[6:0];
   assign funct3   = ir_q[14:12];
   assign f7b5     = ir_q[30];
   assign is_r     = (opcode == 7'b0110011);
   assign is_i     = (opcode == 7'b0010011);
   assign is_lw    = (opcode == 7'b0000011);
   assign is_sw    = (opcode == 7'b0100011);
   assign is_br    = (opcode == 7'b1100011);
   assign is_jal   = (opcode == 7'b1101111);
   assign is_lui   = (opcode == 7'b0110111);
   assign legal    = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_lui;
   assign all_ones = &ir_q;

   // Timeout only exists when MEM_TIMEOUT is non-zero; a hit in the expiry cycle wins.
   assign timeout = (MEM_TIMEOUT > 0) && (cnt_q == CNT_LIM);

   assign rs1    = REG_W'(ir_q[19:15]);
   assign rs2    = REG_W'(ir_q[24:20]);
   assign rd     = REG_W'(ir_q[11:7]);
   assign ALUSrc = is_i | is_lw | is_sw | is_lui | is_jal;
   assign halt   = (state_q == S_HALT);
   assign err    = err_q;

   always_comb begin
      imm32 = 32'd0;
      if (is_i || is_lw)
         imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      else if (is_sw)
         imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      else if (is_br)
         imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      else if (is_lui)
         imm32 = {ir_q[31:12], 12'd0};
      else if (is_jal)
         imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
   end

   assign imm = WORD_W'($signed(imm32));

   // Bit 30 selects SUB only for register ops (it is immediate data in ADDI),
   // but selects SRA for both SRA and SRAI.
   always_comb begin
      aluop4 = 4'd0;
      if (is_br) begin
         aluop4 = 4'd1;
      end else if (is_r || is_i) begin
         case (funct3)
            3'b000:  aluop4 = (is_r && f7b5) ? 4'd1 : 4'd0;
            3'b001:  aluop4 = 4'd5;
            3'b010:  aluop4 = 4'd8;
            3'b011:  aluop4 = 4'd9;
            3'b100:  aluop4 = 4'd4;
            3'b101:  aluop4 = f7b5 ? 4'd7 : 4'd6;
            3'b110:  aluop4 = 4'd3;
            default: aluop4 = 4'd2;
         endcase
      end
   end

   assign ALUOp = ALUOP_W'(aluop4);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state_q <= S_IFETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      err_set  = 1'b0;
      imemREN  = 1'b0;
      irEN     = 1'b0;
      dmemREN  = 1'b0;
      dmemWEN  = 1'b0;
      pcEN     = 1'b0;
      PCSrc    = 1'b0;
      RegWr    = 1'b0;
      MemtoReg = 1'b0;
      case (state_q)
         S_IFETCH: begin
            imemREN = 1'b1;
            if (ihit) begin
               irEN    = 1'b1;
               state_d = S_DECODE;
            end else if (timeout) begin
               err_set = 1'b1;
               state_d = S_HALT;
            end
         end
         S_DECODE: begin
            if (all_ones) begin
               state_d = S_HALT;
            end else if (!legal) begin
               err_set = 1'b1;
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: state_d = (is_lw || is_sw) ? S_MEM : S_WB;
         S_MEM: begin
            dmemREN = is_lw;
            dmemWEN = is_sw;
            if (dhit) begin
               state_d = S_WB;
            end else if (timeout) begin
               err_set = 1'b1;
               state_d = S_HALT;
            end
         end
         S_WB: begin
            pcEN     = 1'b1;
            PCSrc    = pcsrc_q;
            RegWr    = is_r | is_i | is_lw | is_jal | is_lui;
            MemtoReg = is_lw;
            state_d  = S_IFETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IFETCH;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ir_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         pcsrc_q <= 1'b0;
      end else begin
         if (irEN)
            ir_q <= ins;
         // Wait counter restarts on every state entry and saturates while waiting.
         if (state_d != state_q)
            cnt_q <= '0;
         else if (cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + CNT_W'(1);
         if (err_set)
            err_q <= 1'b1;
         if (state_q == S_EXEC)
            pcsrc_q <= (is_br & br_taken) | is_jal;
         else if (state_q == S_WB)
            pcsrc_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm

module tb_multicycle_control_fsm;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] ins;
   logic        ihit, dhit, br_taken;
   logic        imemREN, dmemREN, dmemWEN, irEN, pcEN, PCSrc, RegWr, ALUSrc, MemtoReg;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic [3:0]  ALUOp;
   logic        halt, err;

   multicycle_control_fsm #(
      .WORD_W(32), .REG_W(5), .ALUOP_W(4), .MEM_TIMEOUT(4)
   ) dut (
      .CLK(CLK), .nRST(nRST), .ins(ins), .ihit(ihit), .dhit(dhit), .br_taken(br_taken),
      .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .irEN(irEN), .pcEN(pcEN),
      .PCSrc(PCSrc), .RegWr(RegWr), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .ALUOp(ALUOp), .halt(halt), .err(err)
   );

   always #5 CLK = ~CLK;

   // kind: 0 = no memory phase, 1 = load, 2 = store
   typedef struct {
      logic [31:0] ins;
      int          wi;
      int          wd;
      logic        br;
      int          kind;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic [3:0]  aluop;
      logic        alusrc, regwr, memtoreg, pcsrc;
   } vec_t;

   vec_t tbl[12];
   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   c_imem, c_ren, c_wen, c_pc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; ins = 32'h0; br_taken = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1 nRST = 1'b1;
   endtask

   task automatic clr_counts();
      c_imem = 0; c_ren = 0; c_wen = 0; c_pc = 0;
   endtask

   task automatic step(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge CLK);
         c_imem += int'(imemREN);
         c_ren  += int'(dmemREN);
         c_wen  += int'(dmemWEN);
         c_pc   += int'(pcEN);
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic run_vec(input int k);
      vec_t v, e;
      int   lat, n_mem_r, n_mem_w, n_rw, n_ir;
      logic seen;
      v = tbl[k];
      lat = (v.kind == 0) ? v.wi + 4 : v.wi + v.wd + 5;
      exp_q.push_back(v);
      seen = 1'b0; n_mem_r = 0; n_mem_w = 0; n_rw = 0; n_ir = 0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         ihit     = (c >= v.wi + 1);
         ins      = ihit ? v.ins : 32'h0;
         dhit     = (v.kind == 0) ? 1'b1 : (c == v.wi + 4 + v.wd);
         br_taken = v.br;
         @(negedge CLK);
         n_mem_r += int'(dmemREN);
         n_mem_w += int'(dmemWEN);
         n_rw    += int'(RegWr);
         n_ir    += int'(irEN);
         if (pcEN) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
               check($sformatf("v%0d_queue_nonempty", k), 64'(exp_q.size()), 64'd1);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("v%0d_latency", k), 64'(c), 64'(lat));
               check($sformatf("v%0d_rs1", k), 64'(rs1), 64'(e.rs1));
               check($sformatf("v%0d_rs2", k), 64'(rs2), 64'(e.rs2));
               check($sformatf("v%0d_rd", k), 64'(rd), 64'(e.rd));
               check($sformatf("v%0d_imm", k), 64'(imm), 64'(e.imm));
               check($sformatf("v%0d_aluop", k), 64'(ALUOp), 64'(e.aluop));
               check($sformatf("v%0d_alusrc", k), 64'(ALUSrc), 64'(e.alusrc));
               check($sformatf("v%0d_regwr", k), 64'(RegWr), 64'(e.regwr));
               check($sformatf("v%0d_memtoreg", k), 64'(MemtoReg), 64'(e.memtoreg));
               check($sformatf("v%0d_pcsrc", k), 64'(PCSrc), 64'(e.pcsrc));
            end
         end
         @(posedge CLK);
         #1;
      end
      check($sformatf("v%0d_wb_reached", k), 64'(seen), 64'd1);
      if (!seen && exp_q.size() > 0) void'(exp_q.pop_back());
      check($sformatf("v%0d_dmemren_cycles", k), 64'(n_mem_r), 64'((v.kind == 1) ? v.wd + 1 : 0));
      check($sformatf("v%0d_dmemwen_cycles", k), 64'(n_mem_w), 64'((v.kind == 2) ? v.wd + 1 : 0));
      check($sformatf("v%0d_regwr_cycles", k), 64'(n_rw), 64'(v.regwr ? 1 : 0));
      check($sformatf("v%0d_iren_cycles", k), 64'(n_ir), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      //            ins           wi wd br kind rs1 rs2 rd imm           op src rw m2r pc
      tbl[0]  = '{32'h002081B3, 2, 0, 1'b0, 0, 5'd1, 5'd2,  5'd3,  32'h00000000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{32'hFFC0A283, 0, 3, 1'b0, 1, 5'd1, 5'd28, 5'd5,  32'hFFFFFFFC, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{32'h00208463, 1, 0, 1'b1, 0, 5'd1, 5'd2,  5'd8,  32'h00000008, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{32'h00208463, 0, 0, 1'b0, 0, 5'd1, 5'd2,  5'd8,  32'h00000008, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{32'hFFF00393, 3, 0, 1'b1, 0, 5'd0, 5'd31, 5'd7,  32'hFFFFFFFF, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{32'h0020A423, 1, 2, 1'b0, 2, 5'd1, 5'd2,  5'd8,  32'h00000008, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{32'h010000EF, 0, 0, 1'b0, 0, 5'd0, 5'd16, 5'd1,  32'h00000010, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{32'h12345537, 1, 0, 1'b0, 0, 5'd8, 5'd3,  5'd10, 32'h12345000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{32'h40628233, 0, 0, 1'b0, 0, 5'd5, 5'd6,  5'd4,  32'h00000000, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{32'h4030D093, 2, 0, 1'b0, 0, 5'd1, 5'd3,  5'd1,  32'h00000403, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{32'h0020A423, 0, 4, 1'b0, 2, 5'd1, 5'd2,  5'd8,  32'h00000008, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{32'h002081B3, 4, 0, 1'b0, 0, 5'd1, 5'd2,  5'd3,  32'h00000000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};

      nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; ins = 32'h0; br_taken = 1'b0;
      #2;
      check("rst_imemren", 64'(imemREN), 64'd1);
      check("rst_dmemren", 64'(dmemREN), 64'd0);
      check("rst_dmemwen", 64'(dmemWEN), 64'd0);
      check("rst_pcen", 64'(pcEN), 64'd0);
      check("rst_regwr", 64'(RegWr), 64'd0);
      check("rst_alusrc", 64'(ALUSrc), 64'd0);
      check("rst_fields", 64'({rs1, rs2, rd}), 64'd0);
      check("rst_imm", 64'(imm), 64'd0);
      check("rst_aluop", 64'(ALUOp), 64'd0);
      check("rst_halt_err", 64'({halt, err}), 64'd0);
      @(posedge CLK);
      #1 nRST = 1'b1;

      // Asynchronous reset in the middle of a load's MEM phase.
      ins = 32'hFFC0A283; ihit = 1'b1; dhit = 1'b0;
      @(posedge CLK);
      #1 ihit = 1'b0; ins = 32'h0;
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
         @(negedge CLK);
         if (dmemREN) found = 1'b1;
         else begin
            @(posedge CLK);
            #1;
         end
      end
      check("t1_reached_mem", 64'(found), 64'd1);
      #1 nRST = 1'b0;
      #1;
      check("t1_imemren", 64'(imemREN), 64'd1);
      check("t1_dmemren", 64'(dmemREN), 64'd0);
      check("t1_halt_err", 64'({halt, err}), 64'd0);
      @(posedge CLK);
      #1 nRST = 1'b1;

      // All-ones instruction: clean halt, no further fetches.
      clr_counts();
      ins = 32'hFFFFFFFF; ihit = 1'b1;
      step(8);
      check("t5a_imem_cycles", 64'(c_imem), 64'd1);
      check("t5a_halt", 64'(halt), 64'd1);
      check("t5a_err", 64'(err), 64'd0);
      check("t5a_pcen_cycles", 64'(c_pc), 64'd0);
      do_reset();

      // Illegal opcode 1111111 (not all-ones): halt with error.
      clr_counts();
      ins = 32'h0000007F; ihit = 1'b1;
      step(8);
      check("t5b_imem_cycles", 64'(c_imem), 64'd1);
      check("t5b_halt", 64'(halt), 64'd1);
      check("t5b_err", 64'(err), 64'd1);
      do_reset();

      // Fetch timeout: ihit never arrives.
      clr_counts();
      step(8);
      check("tifetch_imem_cycles", 64'(c_imem), 64'd5);
      check("tifetch_halt", 64'(halt), 64'd1);
      check("tifetch_err", 64'(err), 64'd1);
      do_reset();

      // Store timeout: dhit never arrives.
      clr_counts();
      ins = 32'h0020A423; ihit = 1'b1; dhit = 1'b0;
      step(1);
      ihit = 1'b0;
      step(12);
      check("t6a_dmemwen_cycles", 64'(c_wen), 64'd5);
      check("t6a_pcen_cycles", 64'(c_pc), 64'd0);
      check("t6a_halt", 64'(halt), 64'd1);
      check("t6a_err", 64'(err), 64'd1);
      do_reset();

      for (int k = 0; k < 12; k++) run_vec(k);
      check("table_end_halt_err", 64'({halt, err}), 64'd0);
      check("table_end_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
